// File: rtl/tape_pkg.sv
// Shared definitions for the cassette transport: state codes, default step
// dividers and the prescaler width helper.
package tape_pkg;

  // Transport states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    TS_STOP = 2'd0,
    TS_PLAY = 2'd1,
    TS_FF   = 2'd2,
    TS_REW  = 2'd3
  } tape_state_t;

  // Default clk_sys cycles per position step.
  localparam int unsigned DIV_PLAY_DEFAULT = 6667;
  localparam int unsigned DIV_WIND_DEFAULT = 834;

  // Counter width able to hold 0..max(div_a, div_b)-1, never below one bit.
  function automatic int unsigned psc_width(input int unsigned div_a,
                                            input int unsigned div_b);
    int unsigned m;
    m = (div_a > div_b) ? div_a : div_b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tape_prescaler.sv
// Position-step prescaler: counts enabled cycles 0..term and flags the last
// one of each period with a single-cycle step.
module tape_prescaler #(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] term,
  output logic             step
);

  logic [CNT_W-1:0] count;

  // Step is combinational so the owner moves the position on the same edge
  // that wraps the count; it deliberately ignores clear to avoid a loop
  // through the owner's auto-stop logic.
  assign step = enable && (count == term);

  // Count enabled cycles; clear wins, a low enable freezes the count.
  // NOTE: flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == term) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tape_transport.sv
// Cassette transport controller: play/stop/ff/rew state machine owning the
// virtual tape position, with end-of-tape and start-of-tape auto-stop.
module tape_transport
  import tape_pkg::*;
#(
  parameter int unsigned POS_W    = 24,
  parameter int unsigned DIV_PLAY = DIV_PLAY_DEFAULT,
  parameter int unsigned DIV_WIND = DIV_WIND_DEFAULT
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load,
  input  logic [POS_W-1:0] tape_len,
  input  logic             cmd_play,
  input  logic             cmd_stop,
  input  logic             cmd_ff,
  input  logic             cmd_rew,
  input  logic             motor_in,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] max,
  output logic [1:0]       state,
  output logic             tick,
  output logic             motor_on,
  output logic             at_start,
  output logic             at_end,
  output logic             no_tape
);

  localparam int unsigned PSC_W = psc_width(DIV_PLAY, DIV_WIND);

  tape_state_t      state_q;
  tape_state_t      state_d;
  tape_state_t      cmd_target;
  logic             cmd_hit;
  logic             cmd_change;
  logic [POS_W-1:0] pos_d;
  logic [POS_W-1:0] max_d;
  logic [POS_W-1:0] pos_inc;
  logic [POS_W-1:0] pos_dec;
  logic             tick_d;
  logic             motor_on_d;
  logic             psc_enable;
  logic             psc_clear;
  logic             psc_step;
  logic [PSC_W-1:0] psc_term;

  assign state    = state_q;
  assign at_start = (pos == '0);
  assign at_end   = (pos == max);
  assign no_tape  = (max == '0);
  assign pos_inc  = pos + POS_W'(1);
  assign pos_dec  = pos - POS_W'(1);

  // PLAY advances only with the CPU motor enable; winding is ungated.
  assign psc_enable = ((state_q == TS_PLAY) && motor_in) ||
                      (state_q == TS_FF) || (state_q == TS_REW);
  assign psc_term   = (state_q == TS_PLAY) ? PSC_W'(DIV_PLAY - 1)
                                           : PSC_W'(DIV_WIND - 1);

  tape_prescaler #(
    .CNT_W (PSC_W)
  ) u_prescaler (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .enable  (psc_enable),
    .clear   (psc_clear),
    .term    (psc_term),
    .step    (psc_step)
  );

  // Select the single highest-priority pulse (stop > rew > ff > play), then
  // apply its guard; a blocked winner does not fall through to lower ones.
  // NOTE: every always_comb output gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    cmd_hit    = 1'b0;
    cmd_target = state_q;
    if (cmd_stop) begin
      cmd_hit    = 1'b1;
      cmd_target = TS_STOP;
    end else if (cmd_rew) begin
      cmd_hit    = !at_start;
      cmd_target = TS_REW;
    end else if (cmd_ff) begin
      cmd_hit    = !at_end;
      cmd_target = TS_FF;
    end else if (cmd_play) begin
      cmd_hit    = !at_end;
      cmd_target = TS_PLAY;
    end
    cmd_change = cmd_hit && !no_tape && (cmd_target != state_q);
  end

  // Next state, position and strobes: load beats commands, an accepted state
  // change beats a pending step (that step is dropped with the count).
  always_comb begin
    state_d = state_q;
    pos_d   = pos;
    max_d   = max;
    tick_d  = 1'b0;
    if (load) begin
      state_d = TS_STOP;
      pos_d   = '0;
      max_d   = tape_len;
    end else if (cmd_change) begin
      state_d = cmd_target;
    end else if (psc_step) begin
      unique case (state_q)
        TS_PLAY, TS_FF: begin
          if (!at_end) begin
            pos_d  = pos_inc;
            tick_d = (state_q == TS_PLAY);
            if (pos_inc == max) state_d = TS_STOP;
          end
        end
        TS_REW: begin
          if (!at_start) begin
            pos_d = pos_dec;
            if (pos_dec == '0) state_d = TS_STOP;
          end
        end
        default: ;
      endcase
    end
    psc_clear  = load || (state_d != state_q);
    motor_on_d = (state_d == TS_FF) || (state_d == TS_REW) ||
                 ((state_d == TS_PLAY) && motor_in);
  end

  // Register state, position, length and the registered strobes.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= TS_STOP;
      pos      <= '0;
      max      <= '0;
      tick     <= 1'b0;
      motor_on <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos      <= pos_d;
      max      <= max_d;
      tick     <= tick_d;
      motor_on <= motor_on_d;
    end
  end

endmodule

// File: tb/tb_tape_transport.sv
// Self-checking bench for tape_transport: directed scenarios followed by a
// randomized run, all compared each cycle against a transaction-level model.
module tb_tape_transport;

  localparam int POS_W   = 24;
  localparam int DP      = 4;
  localparam int DW      = 2;
  localparam int ST_STOP = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_FF   = 2;
  localparam int ST_REW  = 3;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic             load;
  logic [POS_W-1:0] tape_len;
  logic             cmd_play;
  logic             cmd_stop;
  logic             cmd_ff;
  logic             cmd_rew;
  logic             motor_in;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] max;
  logic [1:0]       state;
  logic             tick;
  logic             motor_on;
  logic             at_start;
  logic             at_end;
  logic             no_tape;

  always #5 clk_sys = ~clk_sys;

  tape_transport #(
    .POS_W    (POS_W),
    .DIV_PLAY (DP),
    .DIV_WIND (DW)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .load     (load),
    .tape_len (tape_len),
    .cmd_play (cmd_play),
    .cmd_stop (cmd_stop),
    .cmd_ff   (cmd_ff),
    .cmd_rew  (cmd_rew),
    .motor_in (motor_in),
    .pos      (pos),
    .max      (max),
    .state    (state),
    .tick     (tick),
    .motor_on (motor_on),
    .at_start (at_start),
    .at_end   (at_end),
    .no_tape  (no_tape)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transport state, tape position and how many enabled
  // cycles have elapsed since the last step or state entry.
  int          m_state   = ST_STOP;
  int unsigned m_pos     = 0;
  int unsigned m_max     = 0;
  int          m_elapsed = 0;
  bit          m_tick    = 1'b0;
  bit          m_motor   = 1'b0;
  int          tick_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    int target;
    int div;
    bit moving;
    m_tick = 1'b0;
    if (!reset_n) begin
      m_state = ST_STOP; m_pos = 0; m_max = 0; m_elapsed = 0; m_motor = 1'b0;
      return;
    end
    if (load) begin
      m_state = ST_STOP; m_pos = 0; m_max = 32'(tape_len); m_elapsed = 0;
      m_motor = 1'b0;
      return;
    end
    target = -1;
    if (m_max != 0) begin
      if (cmd_stop)      target = ST_STOP;
      else if (cmd_rew)  target = (m_pos == 0)     ? -1 : ST_REW;
      else if (cmd_ff)   target = (m_pos == m_max) ? -1 : ST_FF;
      else if (cmd_play) target = (m_pos == m_max) ? -1 : ST_PLAY;
    end
    if (target >= 0 && target != m_state) begin
      m_state   = target;
      m_elapsed = 0;
    end else begin
      moving = (m_state == ST_FF) || (m_state == ST_REW) ||
               (m_state == ST_PLAY && motor_in);
      if (moving) begin
        m_elapsed++;
        div = (m_state == ST_PLAY) ? DP : DW;
        if (m_elapsed == div) begin
          m_elapsed = 0;
          if (m_state == ST_REW) begin
            m_pos--;
            if (m_pos == 0) m_state = ST_STOP;
          end else begin
            m_tick = (m_state == ST_PLAY);
            m_pos++;
            if (m_pos == m_max) m_state = ST_STOP;
          end
        end
      end
    end
    m_motor = (m_state == ST_FF) || (m_state == ST_REW) ||
              (m_state == ST_PLAY && motor_in);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},    32'(state),    32'(m_state));
    check({tag, ".pos"},      32'(pos),      m_pos);
    check({tag, ".max"},      32'(max),      m_max);
    check({tag, ".tick"},     32'(tick),     32'(m_tick));
    check({tag, ".motor_on"}, 32'(motor_on), 32'(m_motor));
    check({tag, ".at_start"}, 32'(at_start), 32'(m_pos == 0));
    check({tag, ".at_end"},   32'(at_end),   32'(m_pos == m_max));
    check({tag, ".no_tape"},  32'(no_tape),  32'(m_max == 0));
  endtask

  // One edge: update model, sample #1 later, then drop single-cycle pulses.
  task automatic step_clk(input string tag);
    @(posedge clk_sys);
    model_edge();
    #1;
    check_all(tag);
    tick_seen += int'(tick);
    load = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0; cmd_ff = 1'b0;
    cmd_rew = 1'b0;
  endtask

  task automatic wait_pos(input int unsigned target, input int budget,
                          input string tag, output int cycles);
    cycles = 0;
    while (32'(pos) != target && cycles < budget) begin
      step_clk(tag);
      cycles++;
    end
    check({tag, ".reached"}, 32'(pos), target);
  endtask

  task automatic wait_state(input int target, input int budget,
                            input string tag);
    int cycles = 0;
    while (32'(state) != 32'(target) && cycles < budget) begin
      step_clk(tag);
      cycles++;
    end
    check({tag, ".reached"}, 32'(state), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0; load = 1'b0; tape_len = '0; motor_in = 1'b0;
    cmd_play = 1'b0; cmd_stop = 1'b0; cmd_ff = 1'b0; cmd_rew = 1'b0;
    step_clk("reset");
    step_clk("reset");
    check("rst_state", 32'(state), 32'(ST_STOP));
    check("rst_no_tape", 32'(no_tape), 32'd1);
    check("rst_at_end", 32'(at_end), 32'd1);
    reset_n = 1'b1;

    // Full PLAY to end of a 10-position tape.
    tape_len = 24'd10; load = 1'b1;
    step_clk("load10");
    check("load10_max", 32'(max), 32'd10);
    motor_in = 1'b1; cmd_play = 1'b1;
    step_clk("play_cmd");
    check("play_state", 32'(state), 32'(ST_PLAY));
    tick_seen = 0;
    wait_state(ST_STOP, 60, "play_run");
    check("play_end_pos", 32'(pos), 32'd10);
    check("play_last_tick", 32'(tick), 32'd1);
    check("play_ticks", 32'(tick_seen), 32'd10);
    check("play_at_end", 32'(at_end), 32'd1);

    // At end: play and ff are refused, rew winds back to 0.
    cmd_play = 1'b1; step_clk("ign_play");
    check("ign_play_state", 32'(state), 32'(ST_STOP));
    cmd_ff = 1'b1; step_clk("ign_ff");
    check("ign_ff_state", 32'(state), 32'(ST_STOP));
    cmd_rew = 1'b1; step_clk("rew_cmd");
    check("rew_state", 32'(state), 32'(ST_REW));
    tick_seen = 0;
    wait_state(ST_STOP, 40, "rew_run");
    check("rew_end_pos", 32'(pos), 32'd0);
    check("rew_at_start", 32'(at_start), 32'd1);
    check("rew_ticks", 32'(tick_seen), 32'd0);

    // Motor gap mid-count at pos 3.
    cmd_play = 1'b1; step_clk("play2_cmd");
    wait_pos(3, 30, "play2_to3", n);
    step_clk("pre_gap");
    step_clk("pre_gap");
    motor_in = 1'b0;
    tick_seen = 0;
    repeat (7) step_clk("gap");
    check("gap_pos", 32'(pos), 32'd3);
    check("gap_motor", 32'(motor_on), 32'd0);
    check("gap_ticks", 32'(tick_seen), 32'd0);
    motor_in = 1'b1;
    wait_pos(4, 10, "resume", n);
    check("resume_latency", 32'(n), 32'd2);
    check("resume_tick", 32'(tick), 32'd1);
    check("resume_ticks", 32'(tick_seen), 32'd1);
    cmd_stop = 1'b1; step_clk("stop4");

    // Priority during FF at pos 5.
    cmd_ff = 1'b1; step_clk("ff_cmd");
    wait_pos(5, 10, "ff_to5", n);
    cmd_stop = 1'b1; cmd_rew = 1'b1; cmd_play = 1'b1;
    step_clk("prio_stop");
    check("prio_stop_state", 32'(state), 32'(ST_STOP));
    check("prio_stop_pos", 32'(pos), 32'd5);
    cmd_ff = 1'b1; cmd_play = 1'b1;
    step_clk("prio_ff");
    check("prio_ff_state", 32'(state), 32'(ST_FF));

    // Empty tape: everything refused.
    tape_len = 24'd0; load = 1'b1; step_clk("load0");
    check("load0_no_tape", 32'(no_tape), 32'd1);
    cmd_play = 1'b1; step_clk("nt_play");
    cmd_ff = 1'b1; step_clk("nt_ff");
    cmd_rew = 1'b1; step_clk("nt_rew");
    check("nt_state", 32'(state), 32'(ST_STOP));

    // Load while winding.
    tape_len = 24'd10; load = 1'b1; step_clk("reload10");
    cmd_ff = 1'b1; step_clk("ff2_cmd");
    wait_pos(7, 20, "ff_to7", n);
    tape_len = 24'd20; load = 1'b1; step_clk("load20");
    check("load20_state", 32'(state), 32'(ST_STOP));
    check("load20_pos", 32'(pos), 32'd0);
    check("load20_max", 32'(max), 32'd20);
    check("load20_tick", 32'(tick), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      reset_n  = ($urandom_range(0, 399) != 0);
      load     = ($urandom_range(0, 99) < 2);
      tape_len = 24'($urandom_range(0, 12));
      cmd_stop = ($urandom_range(0, 99) < 3);
      cmd_rew  = ($urandom_range(0, 99) < 5);
      cmd_ff   = ($urandom_range(0, 99) < 5);
      cmd_play = ($urandom_range(0, 99) < 8);
      motor_in = ($urandom_range(0, 99) < 80);
      step_clk("rand");
    end
    reset_n = 1'b1; motor_in = 1'b1;

    // Reset overrides a coincident load and command.
    tape_len = 24'd9; load = 1'b1; step_clk("pre_rst_load");
    cmd_play = 1'b1; step_clk("pre_rst_play");
    step_clk("pre_rst_run");
    reset_n = 1'b0; load = 1'b1; tape_len = 24'd5; cmd_play = 1'b1;
    step_clk("rst_mid");
    check("rst2_state", 32'(state), 32'(ST_STOP));
    check("rst2_pos", 32'(pos), 32'd0);
    check("rst2_max", 32'(max), 32'd0);
    check("rst2_tick", 32'(tick), 32'd0);
    check("rst2_motor", 32'(motor_on), 32'd0);
    check("rst2_flags", 32'({no_tape, at_start, at_end}), 32'd7);
    reset_n = 1'b1;
    step_clk("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
